// File: rtl/four_two_pkg.sv
// Shared codes and the encoder output record for the 4-to-2 priority encoder.
// Each request line maps to one fixed 2-bit code.
package four_two_pkg;

    localparam logic [1:0] CODE_P = 2'b00;
    localparam logic [1:0] CODE_Q = 2'b01;
    localparam logic [1:0] CODE_R = 2'b10;
    localparam logic [1:0] CODE_S = 2'b11;

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       multi;
    } enc_out_t;

    localparam enc_out_t ENC_IDLE = '{idx: CODE_P, valid: 1'b0, multi: 1'b0};

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic is_multi(input logic [3:0] req);
        return (req & (req - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/four_two_encoder_if.sv
// Request/result bundle between a requester and the 4-to-2 encoder.
// The master drives the four request lines; the slave returns index and flags.
interface four_two_encoder_if;

    logic p;
    logic q;
    logic r;
    logic s;
    logic a;
    logic b;
    logic valid;
    logic multi;

    modport master (
        output p, q, r, s,
        input  a, b, valid, multi
    );

    modport slave (
        input  p, q, r, s,
        output a, b, valid, multi
    );

endinterface

// File: rtl/four_two_prio.sv
// Pure combinational 4-line priority encoder with selectable priority direction.
// Exactly one win bit is set whenever any request is active.
module four_two_prio
    import four_two_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic       p,
    input  logic       q,
    input  logic       r,
    input  logic       s,
    output logic [1:0] idx,
    output logic       valid,
    output logic       multi
);

    logic [3:0] req;
    logic [3:0] win;

    assign req = {s, r, q, p};

    // A line wins when it is active and no line that outranks it is active.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            localparam logic [3:0] OUTRANK_MASK = (PRIO_HIGH != 0)
                ? (4'b1111 << (gi + 1))
                : ((4'b0001 << gi) - 4'd1);
            assign win[gi] = req[gi] & ~(|(req & OUTRANK_MASK));
        end
    endgenerate

    always_comb begin
        idx = CODE_P;
        case (win)
            4'b0001: idx = CODE_P;
            4'b0010: idx = CODE_Q;
            4'b0100: idx = CODE_R;
            4'b1000: idx = CODE_S;
            default: idx = CODE_P;
        endcase
    end

    assign valid = |req;
    assign multi = is_multi(req);

endmodule

// File: rtl/four_two_encoder.sv
// Registered (or bypassed) 4-to-2 priority encoder with no-input and multi-hot flags.
// Reset clears the outputs immediately in both output modes.
module four_two_encoder
    import four_two_pkg::*;
#(
    parameter int REG_OUT   = 1,
    parameter int PRIO_HIGH = 1
) (
    input  logic               clk,
    input  logic               rst,
    four_two_encoder_if.slave  bus
);

    enc_out_t   enc_next;
    enc_out_t   enc_out;
    logic [1:0] prio_idx;
    logic       prio_valid;
    logic       prio_multi;

    four_two_prio #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_prio (
        .p     (bus.p),
        .q     (bus.q),
        .r     (bus.r),
        .s     (bus.s),
        .idx   (prio_idx),
        .valid (prio_valid),
        .multi (prio_multi)
    );

    assign enc_next = '{idx: prio_idx, valid: prio_valid, multi: prio_multi};

    generate
        if (REG_OUT != 0) begin : g_reg
            enc_out_t enc_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    enc_reg <= ENC_IDLE;
                end else begin
                    enc_reg <= enc_next;
                end
            end

            assign enc_out = enc_reg;
        end else begin : g_bypass
            // Combinational path still honours reset so downstream muxes see idle.
            assign enc_out = rst ? ENC_IDLE : enc_next;
        end
    endgenerate

    assign bus.a     = enc_out.idx[1];
    assign bus.b     = enc_out.idx[0];
    assign bus.valid = enc_out.valid;
    assign bus.multi = enc_out.multi;

endmodule

// File: tb/tb_four_two_encoder.sv
// Scoreboard bench for four_two_encoder across both REG_OUT and PRIO_HIGH settings.
// Registered results are queued at drive time and compared one clock later.
module tb_four_two_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;   // {s, r, q, p}
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_hi_q[$];
    logic [3:0] exp_lo_q[$];

    always #5 clk = ~clk;

    four_two_encoder_if if_rh ();
    four_two_encoder_if if_rl ();
    four_two_encoder_if if_ch ();
    four_two_encoder_if if_cl ();

    assign {if_rh.s, if_rh.r, if_rh.q, if_rh.p} = req;
    assign {if_rl.s, if_rl.r, if_rl.q, if_rl.p} = req;
    assign {if_ch.s, if_ch.r, if_ch.q, if_ch.p} = req;
    assign {if_cl.s, if_cl.r, if_cl.q, if_cl.p} = req;

    four_two_encoder #(.REG_OUT(1), .PRIO_HIGH(1)) u_rh (.clk(clk), .rst(rst), .bus(if_rh));
    four_two_encoder #(.REG_OUT(1), .PRIO_HIGH(0)) u_rl (.clk(clk), .rst(rst), .bus(if_rl));
    four_two_encoder #(.REG_OUT(0), .PRIO_HIGH(1)) u_ch (.clk(clk), .rst(rst), .bus(if_ch));
    four_two_encoder #(.REG_OUT(0), .PRIO_HIGH(0)) u_cl (.clk(clk), .rst(rst), .bus(if_cl));

    // Reference: returns {a, b, valid, multi}
    function automatic logic [3:0] model(input logic [3:0] rq, input bit prio_high);
        int         n = 0;
        logic [1:0] w = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
                n++;
                if (prio_high || n == 1) w = 2'(i);
            end
        end
        return {w, n > 0, n > 1};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {a,b,valid,multi}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] v, input string tag);
        logic [3:0] exp_h;
        logic [3:0] exp_l;
        @(negedge clk);
        req = v;
        #1;
        check({tag, " comb_hi"}, {if_ch.a, if_ch.b, if_ch.valid, if_ch.multi}, model(v, 1'b1));
        check({tag, " comb_lo"}, {if_cl.a, if_cl.b, if_cl.valid, if_cl.multi}, model(v, 1'b0));
        exp_hi_q.push_back(model(v, 1'b1));
        exp_lo_q.push_back(model(v, 1'b0));
        @(posedge clk);
        #1;
        if (exp_hi_q.size() == 0 || exp_lo_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing required an entry", tag);
        end else begin
            exp_h = exp_hi_q.pop_front();
            exp_l = exp_lo_q.pop_front();
            check({tag, " reg_hi"}, {if_rh.a, if_rh.b, if_rh.valid, if_rh.multi}, exp_h);
            check({tag, " reg_lo"}, {if_rl.a, if_rl.b, if_rl.valid, if_rl.multi}, exp_l);
        end
        $display("tx %-8s req(srqp)=%b reg_hi=%b%b%b%b reg_lo=%b%b%b%b", tag, v,
                 if_rh.a, if_rh.b, if_rh.valid, if_rh.multi,
                 if_rl.a, if_rl.b, if_rl.valid, if_rl.multi);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " reg_hi"},  {if_rh.a, if_rh.b, if_rh.valid, if_rh.multi}, 4'b0000);
        check({tag, " reg_lo"},  {if_rl.a, if_rl.b, if_rl.valid, if_rl.multi}, 4'b0000);
        check({tag, " comb_hi"}, {if_ch.a, if_ch.b, if_ch.valid, if_ch.multi}, 4'b0000);
        check({tag, " comb_lo"}, {if_cl.a, if_cl.b, if_cl.valid, if_cl.multi}, 4'b0000);
    endtask

    initial begin
        // Reset with p active, before any rising clock edge
        req = 4'b0001;
        #1 rst = 1'b1;
        #1 check_all_zero("rst_async");

        @(negedge clk);
        rst = 1'b0;

        apply(4'b0001, "p");
        apply(4'b0010, "q");
        apply(4'b0100, "r");
        apply(4'b1000, "s");
        apply(4'b0000, "none");
        apply(4'b1010, "q+s");

        // Reset asserted between edges while s is active
        apply(4'b1000, "s_pre");
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rel reg_hi", {if_rh.a, if_rh.b, if_rh.valid, if_rh.multi}, 4'b1110);
        check("rst_rel reg_lo", {if_rl.a, if_rl.b, if_rl.valid, if_rl.multi}, 4'b1110);

        for (int v = 0; v < 16; v++) begin
            apply(4'(v), $sformatf("sweep%0d", v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
